brkpt_csl_regs: RTL and testbench

Console-side register block that drives the breakpoint address/mask register sets consumed by the breakpoint comparator. It also receives the comparator's one-clock match pulse. It adds arm/disarm control, a programmable skip count, a saturating hit counter and capture of the halting address, then issues the final halt pulse to the CPU and a halt-status interrupt to the console.

---
 rtl/brkpt_csl_regs_if.sv | 20 ++
 rtl/brkpt_csl_regs.sv | 145 ++++++++++++++
 tb/tb_brkpt_csl_regs.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/brkpt_csl_regs_if.sv
// Console bus between the console (master) and the breakpoint register block
// (slave). One-clock read/write strobes, acknowledged one clock later.
interface brkpt_csl_regs_if;
    logic        busWR;
    logic        busRD;
    logic [3:0]  busADDR;
    logic [0:35] busDATAI;
    logic [0:35] busDATAO;
    logic        busACK;

    modport master (
        output busWR, busRD, busADDR, busDATAI,
        input  busDATAO, busACK
    );

    modport slave (
        input  busWR, busRD, busADDR, busDATAI,
        output busDATAO, busACK
    );
endinterface

// File: rtl/brkpt_csl_regs.sv
// Breakpoint console register block: holds the address/mask register sets fed
// to the breakpoint comparator and turns comparator match pulses into a halt
// request. Arm/disarm, skip count, saturating hit counter and capture of the
// halting address are handled here. A console write in the same cycle as a
// match takes effect first; the match then sees the post-write state.
module brkpt_csl_regs #(
    parameter int NUMBR = 4,
    parameter int SKIPW = 16,
    parameter int HITW  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    brkpt_csl_regs_if.slave        bus,
    input  logic                   brMATCH,
    input  logic [0:35]            cpuADDR,
    output logic [0:NUMBR-1][0:35] regBRAR,
    output logic [0:NUMBR-1][0:35] regBRMR,
    output logic                   cpuHALT,
    output logic                   brIRQ
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [HITW-1:0] HIT_MAX = '1;

    state_t           state;
    state_t           wr_state;
    logic [SKIPW-1:0] skip;
    logic [SKIPW-1:0] skip_rem;
    logic [SKIPW-1:0] wr_skip;
    logic [SKIPW-1:0] wr_rem;
    logic [HITW-1:0]  hit;
    logic [HITW-1:0]  wr_hit;
    logic             sat;
    logic             wr_sat;
    logic [0:35]      cap;
    logic [0:35]      rd_val;

    // Post-write view of the control state, which the match logic then acts on
    always_comb begin
        wr_state = state;
        wr_skip  = skip;
        wr_rem   = skip_rem;
        wr_hit   = hit;
        wr_sat   = sat;
        if (bus.busWR) begin
            case (bus.busADDR)
                4'd8: begin
                    if (!bus.busDATAI[35]) begin
                        wr_state = DISARMED;
                    end else if (state == DISARMED ||
                                 (state == HALTED && bus.busDATAI[34])) begin
                        wr_state = ARMED;
                        wr_rem   = skip;
                    end
                end
                4'd9: begin
                    wr_skip = SKIPW'(bus.busDATAI[20:35]);
                    if (state == ARMED) begin
                        wr_rem = wr_skip;
                    end
                end
                4'd11: begin
                    wr_hit = '0;
                    wr_sat = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read data mux; unmapped and reserved bits read as zero
    always_comb begin
        rd_val = '0;
        case (bus.busADDR)
            4'd0, 4'd1, 4'd2, 4'd3: rd_val = regBRAR[bus.busADDR[1:0]];
            4'd4, 4'd5, 4'd6, 4'd7: rd_val = regBRMR[bus.busADDR[1:0]];
            4'd8:  rd_val = {16'(skip_rem), 17'b0, sat, state == HALTED, state != DISARMED};
            4'd9:  rd_val = {{(36-SKIPW){1'b0}}, skip};
            4'd10: rd_val = cap;
            4'd11: rd_val = {{(36-HITW){1'b0}}, hit};
            default: rd_val = '0;
        endcase
    end

    // Bus handshake, register writes and the arm/halt state machine
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= DISARMED;
            skip         <= '0;
            skip_rem     <= '0;
            hit          <= '0;
            sat          <= 1'b0;
            cap          <= '0;
            regBRAR      <= '0;
            regBRMR      <= '0;
            cpuHALT      <= 1'b0;
            bus.busACK   <= 1'b0;
            bus.busDATAO <= '0;
        end else begin
            bus.busACK   <= bus.busRD | bus.busWR;
            bus.busDATAO <= (bus.busRD && !bus.busWR) ? rd_val : '0;
            cpuHALT      <= 1'b0;

            if (bus.busWR && !bus.busADDR[3]) begin
                if (bus.busADDR[2]) begin
                    regBRMR[bus.busADDR[1:0]] <= bus.busDATAI;
                end else begin
                    regBRAR[bus.busADDR[1:0]] <= bus.busDATAI;
                end
            end

            state    <= wr_state;
            skip     <= wr_skip;
            skip_rem <= wr_rem;
            hit      <= wr_hit;
            sat      <= wr_sat;

            if (brMATCH && wr_state != DISARMED) begin
                if (wr_hit != HIT_MAX) begin
                    hit <= wr_hit + 1'b1;
                end
                if (wr_hit >= HIT_MAX - 1'b1) begin
                    sat <= 1'b1;
                end
                if (wr_state == ARMED) begin
                    if (wr_rem == '0) begin
                        cap     <= cpuADDR;
                        cpuHALT <= 1'b1;
                        state   <= HALTED;
                    end else begin
                        skip_rem <= wr_rem - 1'b1;
                    end
                end
            end
        end
    end

    assign brIRQ = (state == HALTED);

endmodule

// File: tb/tb_brkpt_csl_regs.sv
// Bench for brkpt_csl_regs. A second instance with a 4-bit hit counter is used
// to reach saturation in a few dozen cycles; 'sel' routes stimulus and
// observed outputs to one instance at a time.
module tb_brkpt_csl_regs;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [0:35] data;
        logic [0:35] exp;
    } vec_t;

    localparam logic [0:35] CA   = 36'o040000_001000;
    localparam logic [0:35] ONES = 36'o777777_777777;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        match = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  addr = '0;
    logic [0:35] datai = '0;
    logic [0:35] cpu_addr = '0;

    logic [0:3][0:35] brar, brmr, brar_s, brmr_s;
    logic             halt_m, irq_m, halt_s, irq_s;
    logic             ack, halt, irq;
    logic [0:35]      dato;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs [14];

    brkpt_csl_regs_if bus ();
    brkpt_csl_regs_if bus_s ();

    assign bus.busWR      = wr & ~sel;
    assign bus.busRD      = rd & ~sel;
    assign bus.busADDR    = addr;
    assign bus.busDATAI   = datai;
    assign bus_s.busWR    = wr & sel;
    assign bus_s.busRD    = rd & sel;
    assign bus_s.busADDR  = addr;
    assign bus_s.busDATAI = datai;

    assign ack  = sel ? bus_s.busACK   : bus.busACK;
    assign dato = sel ? bus_s.busDATAO : bus.busDATAO;
    assign halt = sel ? halt_s : halt_m;
    assign irq  = sel ? irq_s  : irq_m;

    brkpt_csl_regs dut (
        .clk(clk), .rst(rst), .bus(bus),
        .brMATCH(match & ~sel), .cpuADDR(cpu_addr),
        .regBRAR(brar), .regBRMR(brmr),
        .cpuHALT(halt_m), .brIRQ(irq_m)
    );

    brkpt_csl_regs #(.HITW(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s),
        .brMATCH(match & sel), .cpuADDR(cpu_addr),
        .regBRAR(brar_s), .regBRMR(brmr_s),
        .cpuHALT(halt_s), .brIRQ(irq_s)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [0:35] actual,
                               input logic [0:35] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One bus cycle: strobes and match held for exactly one clock
    task automatic busOp(input logic w, input logic r, input logic [3:0] a,
                         input logic [0:35] d, input logic m);
        wr = w; rd = r; addr = a; datai = d; match = m;
        tick();
        wr = 1'b0; rd = 1'b0; match = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        busOp(v.wr, v.rd, v.addr, v.data, 1'b0);
        checkOutput($sformatf("vec%0d_ack", idx), 36'(ack), 36'd1);
        checkOutput($sformatf("vec%0d_data", idx), dato, v.exp);
    endtask

    task automatic readReg(input logic [3:0] a, input string name, input logic [0:35] exp);
        busOp(1'b0, 1'b1, a, '0, 1'b0);
        checkOutput({name, "_ack"}, 36'(ack), 36'd1);
        checkOutput(name, dato, exp);
    endtask

    task automatic writeReg(input logic [3:0] a, input logic [0:35] d);
        busOp(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic pulseMatch(input logic [0:35] ca, input string name, input logic exp_halt);
        cpu_addr = ca;
        busOp(1'b0, 1'b0, 4'd0, '0, 1'b1);
        checkOutput(name, 36'(halt), 36'(exp_halt));
    endtask

    initial begin
        int halt_cnt;

        // Register access vectors: {wr, rd, addr, data, expected read data}
        vecs[0]  = '{1'b1, 1'b0, 4'd6,  ONES,      36'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'd2,  36'd0,     36'o000000_001000};
        vecs[2]  = '{1'b0, 1'b1, 4'd6,  36'd0,     ONES};
        vecs[3]  = '{1'b1, 1'b0, 4'd12, ONES,      36'd0};
        vecs[4]  = '{1'b0, 1'b1, 4'd12, 36'd0,     36'd0};
        vecs[5]  = '{1'b1, 1'b0, 4'd9,  ONES,      36'd0};
        vecs[6]  = '{1'b0, 1'b1, 4'd9,  36'd0,     36'h0_0000_FFFF};
        vecs[7]  = '{1'b1, 1'b0, 4'd10, ONES,      36'd0};
        vecs[8]  = '{1'b0, 1'b1, 4'd10, 36'd0,     36'd0};
        vecs[9]  = '{1'b1, 1'b1, 4'd0,  36'o123,   36'd0};
        vecs[10] = '{1'b0, 1'b1, 4'd0,  36'd0,     36'o123};
        vecs[11] = '{1'b1, 1'b0, 4'd9,  36'd2,     36'd0};
        vecs[12] = '{1'b0, 1'b1, 4'd9,  36'd0,     36'd2};
        vecs[13] = '{1'b0, 1'b1, 4'd8,  36'd0,     36'd0};

        $display("[TB] reset");
        rst = 1'b0;
        tick();
        tick();
        checkOutput("rst_ack", 36'(ack), 36'd0);
        checkOutput("rst_dato", dato, 36'd0);
        checkOutput("rst_halt", 36'(halt), 36'd0);
        checkOutput("rst_irq", 36'(irq), 36'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst_brar%0d", i), brar[i], 36'd0);
            checkOutput($sformatf("rst_brmr%0d", i), brmr[i], 36'd0);
        end
        rst = 1'b1;

        $display("[TB] back-to-back reads of all addresses");
        rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            checkOutput($sformatf("rd%0d_ack", i), 36'(ack), 36'd1);
            checkOutput($sformatf("rd%0d_data", i), dato, 36'd0);
        end
        rd = 1'b0;
        tick();
        checkOutput("ack_drops", 36'(ack), 36'd0);

        $display("[TB] BRAR2 write timing");
        wr = 1'b1; addr = 4'd2; datai = 36'o000000_001000;
        #1;
        checkOutput("brar2_before_edge", brar[2], 36'd0);
        @(posedge clk);
        #1;
        wr = 1'b0;
        checkOutput("brar2_after_edge", brar[2], 36'o000000_001000);
        checkOutput("brar2_wr_ack", 36'(ack), 36'd1);

        $display("[TB] register vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end
        checkOutput("brmr2_out", brmr[2], ONES);

        $display("[TB] arm with skip 2");
        writeReg(4'd8, 36'd1);
        readReg(4'd8, "sr_armed", 36'h0_0020_0001);
        pulseMatch(CA, "m1_halt", 1'b0);
        readReg(4'd8, "sr_rem1", 36'h0_0010_0001);
        pulseMatch(CA, "m2_halt", 1'b0);
        readReg(4'd8, "sr_rem0", 36'h0_0000_0001);
        pulseMatch(CA, "m3_halt", 1'b1);
        tick();
        checkOutput("halt_one_clock", 36'(halt), 36'd0);
        checkOutput("irq_halted", 36'(irq), 36'd1);
        readReg(4'd10, "cap", CA);
        readReg(4'd8, "sr_halted", 36'd3);
        readReg(4'd11, "hit3", 36'd3);

        $display("[TB] matches while halted, then acknowledge");
        pulseMatch(36'o111, "h1_halt", 1'b0);
        pulseMatch(36'o111, "h2_halt", 1'b0);
        readReg(4'd11, "hit5", 36'd5);
        readReg(4'd10, "cap_kept", CA);
        writeReg(4'd8, 36'o000000_000003);
        checkOutput("irq_after_ack", 36'(irq), 36'd0);
        readReg(4'd8, "sr_rearmed", 36'h0_0020_0001);

        $display("[TB] hit clear coincident with match");
        busOp(1'b1, 1'b0, 4'd11, 36'd0, 1'b1);
        checkOutput("clr_match_halt", 36'(halt), 36'd0);
        readReg(4'd11, "hit_clr_match", 36'd1);
        readReg(4'd8, "sr_after_clr", 36'h0_0010_0001);

        $display("[TB] disarmed matches are ignored");
        writeReg(4'd8, 36'd0);
        cpu_addr = 36'o222;
        halt_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            busOp(1'b0, 1'b0, 4'd0, '0, 1'b1);
            if (halt) halt_cnt++;
        end
        checkOutput("disarm_halts", 36'(halt_cnt), 36'd0);
        readReg(4'd11, "disarm_hit", 36'd1);
        readReg(4'd10, "disarm_cap", CA);

        $display("[TB] acknowledge with skip 0 plus match re-halts");
        writeReg(4'd9, 36'd0);
        writeReg(4'd8, 36'd1);
        pulseMatch(36'o333, "rh1_halt", 1'b1);
        checkOutput("rh1_irq", 36'(irq), 36'd1);
        cpu_addr = 36'o444;
        busOp(1'b1, 1'b0, 4'd8, 36'd3, 1'b1);
        checkOutput("ack_rehalt", 36'(halt), 36'd1);
        checkOutput("ack_rehalt_irq", 36'(irq), 36'd1);
        readReg(4'd10, "rehalt_cap", 36'o444);
        readReg(4'd11, "rehalt_hit", 36'd3);

        $display("[TB] reset during a pending read");
        rst = 1'b0; rd = 1'b1; addr = 4'd2;
        tick();
        rd = 1'b0;
        checkOutput("midrst_ack", 36'(ack), 36'd0);
        checkOutput("midrst_dato", dato, 36'd0);
        checkOutput("midrst_halt", 36'(halt), 36'd0);
        checkOutput("midrst_irq", 36'(irq), 36'd0);
        checkOutput("midrst_brar2", brar[2], 36'd0);
        checkOutput("midrst_brmr2", brmr[2], 36'd0);
        rst = 1'b1;
        readReg(4'd11, "post_rst_hit", 36'd0);
        readReg(4'd10, "post_rst_cap", 36'd0);

        $display("[TB] saturation on the 4-bit hit counter instance");
        sel = 1'b1;
        writeReg(4'd9, 36'h0_0000_FFFF);
        writeReg(4'd8, 36'd1);
        for (int i = 0; i < 14; i++) begin
            busOp(1'b0, 1'b0, 4'd0, '0, 1'b1);
        end
        readReg(4'd11, "sat_hit14", 36'd14);
        readReg(4'd8, "sat_sr14", 36'hFFF1_0000_1);
        pulseMatch(CA, "sat_m15", 1'b0);
        pulseMatch(CA, "sat_m16", 1'b0);
        pulseMatch(CA, "sat_m17", 1'b0);
        readReg(4'd11, "sat_hit_max", 36'd15);
        readReg(4'd8, "sat_sr_set", 36'hFFEE_0000_5);
        busOp(1'b1, 1'b0, 4'd11, 36'd0, 1'b1);
        readReg(4'd11, "sat_clr_hit", 36'd1);
        readReg(4'd8, "sat_clr_sr", 36'hFFED_0000_1);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
